reorder_buffer: RTL



---
 rtl/reorder_buffer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates ROB ids, captures CDB results, retires to RF/LSB, flushes on mispredict.
// Optional ROB_CDB_BYPASS_EN: operand queries see a same-cycle CDB broadcast.
`timescale 1ns/1ps
module reorder_buffer #(
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int XLEN           = 32,
  parameter int REG_CNT_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      dec_ready,
  input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
  input  logic                      dec_has_rd,
  input  logic                      dec_is_store,
  input  logic                      cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] cdb_id,
  input  logic [XLEN-1:0]           cdb_val,
  input  logic                      cdb_mispredict,
  input  logic [XLEN-1:0]           cdb_target,
  input  logic [ROB_SIZE_WIDTH-1:0] query1_id,
  input  logic [ROB_SIZE_WIDTH-1:0] query2_id,
  output logic                      query1_ready,
  output logic                      query2_ready,
  output logic [XLEN-1:0]           query1_val,
  output logic [XLEN-1:0]           query2_val,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  output logic                      rob_rf_enable,
  output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd,
  output logic [XLEN-1:0]           rob_rf_val,
  output logic                      rob_store_commit,
  output logic [ROB_SIZE_WIDTH-1:0] rob_store_id,
  output logic                      rob_flush,
  output logic [XLEN-1:0]           rob_flush_pc
);

  // state      | meaning
  // ST_RUN     | normal dispatch / capture / commit
  // ST_FLUSH_W | mispredict retired; its rf write is visible, pipeline frozen
  // ST_FLUSH   | rob_flush asserted; queue is emptied on exit
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH_W, ST_FLUSH} state_t;

  localparam int ROB_SIZE = 1 << ROB_SIZE_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0]   FULL_CNT = {1'b0, {ROB_SIZE_WIDTH{1'b1}}};
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_ONE  = {{ROB_SIZE_WIDTH{1'b0}}, 1'b1};
  localparam logic [ROB_SIZE_WIDTH-1:0] PTR_ONE  = {{(ROB_SIZE_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state;
  logic [ROB_SIZE_WIDTH-1:0] head, tail;
  logic [ROB_SIZE_WIDTH:0]   count;
  logic [ROB_SIZE-1:0]       busy, done, has_rd, is_store, mis;
  logic [REG_CNT_WIDTH-1:0]  rd_q  [ROB_SIZE];
  logic [XLEN-1:0]           val_q [ROB_SIZE];
  logic [XLEN-1:0]           tgt_q [ROB_SIZE];
  logic [XLEN-1:0]           flush_tgt;

  logic do_disp, do_commit, cdb_hit;

  assign rob_full    = count >= FULL_CNT;
  assign rob_head_id = head;
  assign rob_tail_id = tail;
  assign do_disp     = (state == ST_RUN) && dec_ready && !rob_full;
  assign do_commit   = (state == ST_RUN) && busy[head] && done[head];
  assign cdb_hit     = (state == ST_RUN) && cdb_valid && busy[cdb_id];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_RUN;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      done             <= '0;
      has_rd           <= '0;
      is_store         <= '0;
      mis              <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        tgt_q[i] <= '0;
      end
      flush_tgt        <= '0;
      rob_rf_enable    <= 1'b0;
      rob_rf_rd        <= '0;
      rob_rf_val       <= '0;
      rob_store_commit <= 1'b0;
      rob_store_id     <= '0;
      rob_flush        <= 1'b0;
      rob_flush_pc     <= '0;
    end else if (rdy) begin
      rob_rf_enable    <= 1'b0;
      rob_store_commit <= 1'b0;
      rob_flush        <= 1'b0;
      case (state)
        ST_RUN: begin
          if (cdb_hit) begin
            done[cdb_id]  <= 1'b1;
            val_q[cdb_id] <= cdb_val;
            mis[cdb_id]   <= cdb_mispredict;
            tgt_q[cdb_id] <= cdb_target;
          end
          // dispatch never lands on the CDB target or the committing slot: tail is not busy
          if (do_disp) begin
            busy[tail]     <= 1'b1;
            done[tail]     <= 1'b0;
            has_rd[tail]   <= dec_has_rd;
            is_store[tail] <= dec_is_store;
            rd_q[tail]     <= dec_rd;
            tail           <= tail + PTR_ONE;
          end
          if (do_commit) begin
            busy[head]       <= 1'b0;
            head             <= head + PTR_ONE;
            rob_rf_enable    <= has_rd[head] && (rd_q[head] != '0);
            rob_rf_rd        <= rd_q[head];
            rob_rf_val       <= val_q[head];
            rob_store_commit <= is_store[head];
            rob_store_id     <= head;
            if (mis[head]) begin
              flush_tgt <= tgt_q[head];
              state     <= ST_FLUSH_W;
            end
          end
          if (do_disp && !do_commit)
            count <= count + CNT_ONE;
          else if (!do_disp && do_commit)
            count <= count - CNT_ONE;
        end
        ST_FLUSH_W: begin
          rob_flush    <= 1'b1;
          rob_flush_pc <= flush_tgt;
          state        <= ST_FLUSH;
        end
        ST_FLUSH: begin
          busy  <= '0;
          tail  <= head;
          count <= '0;
          state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef ROB_CDB_BYPASS_EN
  always_comb begin
    query1_ready = busy[query1_id] && done[query1_id];
    query1_val   = val_q[query1_id];
    if (cdb_valid && (cdb_id == query1_id)) begin
      query1_ready = 1'b1;
      query1_val   = cdb_val;
    end
  end

  always_comb begin
    query2_ready = busy[query2_id] && done[query2_id];
    query2_val   = val_q[query2_id];
    if (cdb_valid && (cdb_id == query2_id)) begin
      query2_ready = 1'b1;
      query2_val   = cdb_val;
    end
  end
`else
  assign query1_ready = busy[query1_id] && done[query1_id];
  assign query1_val   = val_q[query1_id];
  assign query2_ready = busy[query2_id] && done[query2_id];
  assign query2_val   = val_q[query2_id];
`endif

endmodule
